// File: rtl/nes_mem_pkg.sv
// Shared constants for the NES memory arbiter: FSM encoding, port IDs and
// the default RAM address width.
package nes_mem_pkg;

  localparam int NES_ADDR_W = 22;

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_READ_WAIT = 1'b1;

  localparam logic [0:0] PORT_CPU = 1'b0;
  localparam logic [0:0] PORT_PPU = 1'b1;

endpackage

// File: rtl/nes_mem_req_slot.sv
// One pending-request slot. A new pulse always wins over a stale entry; if the
// stale entry had not been issued yet, the sticky overrun flag is raised.
module nes_mem_req_slot
  import nes_mem_pkg::*;
#(
  parameter int ADDR_W = NES_ADDR_W
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              req_i,
  input  logic              req_wr_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [7:0]        req_din_i,
  input  logic              take_i,
  output logic              pending_o,
  output logic              wr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        din_o,
  output logic              overrun_o
);

  logic              pend_q, pend_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              ovr_q, ovr_d;

  // Next slot contents: flush beats a new request, which beats a grant.
  always_comb begin
    pend_d = pend_q;
    wr_d   = wr_q;
    addr_d = addr_q;
    din_d  = din_q;
    ovr_d  = ovr_q;
    if (flush_i) begin
      pend_d = 1'b0;
    end else if (req_i) begin
      pend_d = 1'b1;
      wr_d   = req_wr_i;
      addr_d = req_addr_i;
      din_d  = req_din_i;
      // Being granted in this same cycle means the old entry was not lost.
      if (pend_q && !take_i) ovr_d = 1'b1;
    end else if (take_i) begin
      pend_d = 1'b0;
    end
  end

  // Slot registers with synchronous clear.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pend_q <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pending_o = pend_q;
  assign wr_o      = wr_q;
  assign addr_o    = addr_q;
  assign din_o     = din_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/nes_mem_arbiter.sv
// Single-port RAM arbiter for loader, CPU and PPU.
//
//   state        | meaning
//   ST_IDLE      | free; grants a pending slot (PPU first) combinationally
//   ST_READ_WAIT | read issued; counting down RAM latency, then capture
module nes_mem_arbiter
  import nes_mem_pkg::*;
#(
  parameter int ADDR_W = NES_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              ld_active_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic              ld_wr_i,
  input  logic [7:0]        ld_din_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [7:0]        cpu_din_i,
  output logic [7:0]        cpu_q_o,
  output logic              cpu_valid_o,
  input  logic [ADDR_W-1:0] ppu_addr_i,
  input  logic              ppu_rd_i,
  output logic [7:0]        ppu_q_o,
  output logic              ppu_valid_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_din_o,
  input  logic [7:0]        ram_dout_i,
  output logic              overrun_o
);

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT);

  logic              cpu_pend, cpu_wr_s, cpu_ovr;
  logic [ADDR_W-1:0] cpu_addr_s;
  logic [7:0]        cpu_din_s;
  logic              ppu_pend, ppu_ovr;
  logic [ADDR_W-1:0] ppu_addr_s;
  logic              ppu_wr_unused;
  logic [7:0]        ppu_din_unused;

  logic              grant_ok, grant_ppu, grant_cpu, grant_wr, grant_rd, grant_any;
  logic [ADDR_W-1:0] grant_addr;

  logic [0:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [0:0]        port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              ld_we_q, ld_we_d;
  logic [7:0]        cpu_q_q, cpu_q_d, ppu_q_q, ppu_q_d;
  logic              cpu_v_q, cpu_v_d, ppu_v_q, ppu_v_d;

  nes_mem_req_slot #(.ADDR_W(ADDR_W)) u_cpu_slot (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .flush_i    (ld_active_i),
    .req_i      ((cpu_rd_i | cpu_wr_i) & ~ld_active_i),
    .req_wr_i   (cpu_wr_i),
    .req_addr_i (cpu_addr_i),
    .req_din_i  (cpu_din_i),
    .take_i     (grant_cpu),
    .pending_o  (cpu_pend),
    .wr_o       (cpu_wr_s),
    .addr_o     (cpu_addr_s),
    .din_o      (cpu_din_s),
    .overrun_o  (cpu_ovr)
  );

  nes_mem_req_slot #(.ADDR_W(ADDR_W)) u_ppu_slot (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .flush_i    (ld_active_i),
    .req_i      (ppu_rd_i & ~ld_active_i),
    .req_wr_i   (1'b0),
    .req_addr_i (ppu_addr_i),
    .req_din_i  (8'h00),
    .take_i     (grant_ppu),
    .pending_o  (ppu_pend),
    .wr_o       (ppu_wr_unused),
    .addr_o     (ppu_addr_s),
    .din_o      (ppu_din_unused),
    .overrun_o  (ppu_ovr)
  );

  // Grant selection: PPU has fixed priority since its fetch window is tighter.
  always_comb begin
    grant_ok   = (state_q == ST_IDLE) && !ld_active_i && !reset_i;
    grant_ppu  = grant_ok && ppu_pend;
    grant_cpu  = grant_ok && cpu_pend && !ppu_pend;
    grant_wr   = grant_cpu && cpu_wr_s;
    grant_rd   = grant_ppu || (grant_cpu && !cpu_wr_s);
    grant_any  = grant_ppu || grant_cpu;
    grant_addr = grant_ppu ? ppu_addr_s : cpu_addr_s;
  end

  // FSM next state, held RAM drive and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ld_we_d = ld_active_i && ld_wr_i;
    cpu_q_d = cpu_q_q;
    ppu_q_d = ppu_q_q;
    cpu_v_d = 1'b0;
    ppu_v_d = 1'b0;

    if (ld_active_i && ld_wr_i) begin
      addr_d = ld_addr_i;
      din_d  = ld_din_i;
    end else if (grant_any) begin
      addr_d = grant_addr;
      if (grant_wr) din_d = cpu_din_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_rd) begin
          state_d = ST_READ_WAIT;
          cnt_d   = LAT_LOAD;
          port_d  = grant_ppu ? PORT_PPU : PORT_CPU;
        end
      end
      ST_READ_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = ST_IDLE;
          // Data still lands while the loader owns the RAM; only the pulse is hidden.
          if (port_q == PORT_PPU) begin
            ppu_q_d = ram_dout_i;
            ppu_v_d = !ld_active_i;
          end else begin
            cpu_q_d = ram_dout_i;
            cpu_v_d = !ld_active_i;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      port_q  <= PORT_CPU;
      addr_q  <= '0;
      din_q   <= 8'h00;
      ld_we_q <= 1'b0;
      cpu_q_q <= 8'h00;
      ppu_q_q <= 8'h00;
      cpu_v_q <= 1'b0;
      ppu_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ld_we_q <= ld_we_d;
      cpu_q_q <= cpu_q_d;
      ppu_q_q <= ppu_q_d;
      cpu_v_q <= cpu_v_d;
      ppu_v_q <= ppu_v_d;
    end
  end

  // The issue cycle drives the RAM directly so a read costs RD_LAT+1 cycles.
  assign ram_addr_o  = grant_any ? grant_addr : addr_q;
  assign ram_din_o   = grant_wr ? cpu_din_s : din_q;
  assign ram_we_o    = ld_we_q | grant_wr;
  assign cpu_q_o     = cpu_q_q;
  assign ppu_q_o     = ppu_q_q;
  assign cpu_valid_o = cpu_v_q | grant_wr;
  assign ppu_valid_o = ppu_v_q;
  assign overrun_o   = cpu_ovr | ppu_ovr;

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Scoreboard bench for nes_mem_arbiter with a 1-cycle-latency RAM model.
module tb_nes_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ld_active, ld_wr, cpu_rd, cpu_wr, ppu_rd;
  logic [21:0] ld_addr, cpu_addr, ppu_addr;
  logic [7:0]  ld_din, cpu_din;
  logic [7:0]  cpu_q, ppu_q, ram_din, ram_dout;
  logic        cpu_valid, ppu_valid, ram_we, overrun;
  logic [21:0] ram_addr;

  nes_mem_arbiter #(.ADDR_W(22), .RD_LAT(1)) dut (
    .clock_i(clock), .reset_i(reset),
    .ld_active_i(ld_active), .ld_addr_i(ld_addr), .ld_wr_i(ld_wr), .ld_din_i(ld_din),
    .cpu_addr_i(cpu_addr), .cpu_rd_i(cpu_rd), .cpu_wr_i(cpu_wr), .cpu_din_i(cpu_din),
    .cpu_q_o(cpu_q), .cpu_valid_o(cpu_valid),
    .ppu_addr_i(ppu_addr), .ppu_rd_i(ppu_rd), .ppu_q_o(ppu_q), .ppu_valid_o(ppu_valid),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_din_o(ram_din), .ram_dout_i(ram_dout),
    .overrun_o(overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous RAM, 1-cycle read latency.
  logic [7:0] mem [0:4095];
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr[11:0]] <= ram_din;
    ram_dout <= mem[ram_addr[11:0]];
  end

  typedef struct { int cyc; logic [7:0] data; bit chk; } rd_exp_t;
  typedef struct { int cyc; logic [21:0] addr; logic [7:0] data; } wr_exp_t;
  typedef struct { int cyc; int sig; logic [31:0] val; string name; } probe_t;

  rd_exp_t cpu_exp[$];
  rd_exp_t ppu_exp[$];
  wr_exp_t wr_exp[$];
  probe_t  probes[$];

  int n_vec = 0;
  int n_err = 0;
  bit stim_done = 0;
  int drain = 0;

  localparam int S_ADDR = 0, S_WE = 1, S_DIN = 2, S_CPUQ = 3, S_PPUQ = 4,
                 S_CPUV = 5, S_PPUV = 6, S_OVR = 7;

  function automatic logic [31:0] sample(input int id);
    case (id)
      S_ADDR:  return 32'(ram_addr);
      S_WE:    return 32'(ram_we);
      S_DIN:   return 32'(ram_din);
      S_CPUQ:  return 32'(cpu_q);
      S_PPUQ:  return 32'(ppu_q);
      S_CPUV:  return 32'(cpu_valid);
      S_PPUV:  return 32'(ppu_valid);
      S_OVR:   return 32'(overrun);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents something.
  rd_exp_t mc, mp;
  wr_exp_t mw;
  probe_t  pr;
  always @(negedge clock) begin
    while (probes.size() != 0 && probes[0].cyc <= cyc) begin
      pr = probes.pop_front();
      check(pr.name, sample(pr.sig), pr.val);
    end
    if (cpu_valid) begin
      if (cpu_exp.size() == 0) check("cpu_valid_unexpected", 32'(cpu_valid), 32'd0);
      else begin
        mc = cpu_exp.pop_front();
        check("cpu_valid_cycle", 32'(cyc), 32'(mc.cyc));
        if (mc.chk) check("cpu_q", 32'(cpu_q), 32'(mc.data));
      end
    end
    if (ppu_valid) begin
      if (ppu_exp.size() == 0) check("ppu_valid_unexpected", 32'(ppu_valid), 32'd0);
      else begin
        mp = ppu_exp.pop_front();
        check("ppu_valid_cycle", 32'(cyc), 32'(mp.cyc));
        check("ppu_q", 32'(ppu_q), 32'(mp.data));
      end
    end
    if (ram_we) begin
      if (wr_exp.size() == 0) check("ram_we_unexpected", 32'(ram_we), 32'd0);
      else begin
        mw = wr_exp.pop_front();
        check("ram_we_cycle", 32'(cyc), 32'(mw.cyc));
        check("ram_we_addr", 32'(ram_addr), 32'(mw.addr));
        check("ram_we_din", 32'(ram_din), 32'(mw.data));
      end
    end
    if (stim_done) begin
      drain++;
      if ((cpu_exp.size() == 0 && ppu_exp.size() == 0 && wr_exp.size() == 0 &&
           probes.size() == 0) || drain > 40) begin
        while (cpu_exp.size() != 0) begin
          mc = cpu_exp.pop_front(); n_vec++; n_err++;
          $display("FAIL cpu_valid_missing: expected at cycle %0d, no pulse observed by end of run", mc.cyc);
        end
        while (ppu_exp.size() != 0) begin
          mp = ppu_exp.pop_front(); n_vec++; n_err++;
          $display("FAIL ppu_valid_missing: expected at cycle %0d, no pulse observed by end of run", mp.cyc);
        end
        while (wr_exp.size() != 0) begin
          mw = wr_exp.pop_front(); n_vec++; n_err++;
          $display("FAIL ram_we_missing: expected at cycle %0d, no write observed by end of run", mw.cyc);
        end
        while (probes.size() != 0) begin
          pr = probes.pop_front(); n_vec++; n_err++;
          $display("FAIL %s: never sampled, expected at cycle %0d", pr.name, pr.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    ppu_rd = 1'b0;
    ld_wr  = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic probe(input string nm, input int sig, input logic [31:0] v);
    probes.push_back('{cyc, sig, v, nm});
  endtask

  task automatic exp_cpu(input int c, input logic [7:0] d, input bit chk);
    cpu_exp.push_back('{c, d, chk});
  endtask

  task automatic exp_ppu(input int c, input logic [7:0] d);
    ppu_exp.push_back('{c, d, 1'b1});
  endtask

  task automatic exp_wr(input int c, input logic [21:0] a, input logic [7:0] d);
    wr_exp.push_back('{c, a, d});
  endtask

  logic [21:0] pre_addr [6] = '{22'h100, 22'h010, 22'h020, 22'h030, 22'h040, 22'h041};
  logic [7:0]  pre_data [6] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
  int r;

  initial begin
    reset = 1'b1; ld_active = 0; ld_wr = 0; cpu_rd = 0; cpu_wr = 0; ppu_rd = 0;
    ld_addr = '0; cpu_addr = '0; ppu_addr = '0; ld_din = '0; cpu_din = '0;
    tick_n(3);
    probe("rst_ram_addr", S_ADDR, 32'h0);
    probe("rst_ram_we",   S_WE,   32'h0);
    probe("rst_ram_din",  S_DIN,  32'h0);
    probe("rst_cpu_q",    S_CPUQ, 32'h0);
    probe("rst_ppu_q",    S_PPUQ, 32'h0);
    probe("rst_cpu_valid",S_CPUV, 32'h0);
    probe("rst_ppu_valid",S_PPUV, 32'h0);
    probe("rst_overrun",  S_OVR,  32'h0);
    reset = 1'b0;
    tick_n(2);

    // Preload the RAM through the loader path.
    ld_active = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ld_addr = pre_addr[i]; ld_din = pre_data[i]; ld_wr = 1'b1;
      exp_wr(cyc + 1, pre_addr[i], pre_data[i]);
      tick();
    end
    ld_active = 1'b0;
    tick_n(3);

    // Single CPU read.
    r = cyc; cpu_addr = 22'h100; cpu_rd = 1'b1;
    exp_cpu(r + 3, 8'hA5, 1'b1);
    tick();
    probe("t1_issue_addr", S_ADDR, 32'h100);
    probe("t1_issue_we",   S_WE,   32'h0);
    tick_n(6);

    // Simultaneous CPU + PPU reads: PPU first, CPU back-to-back.
    r = cyc; cpu_addr = 22'h010; ppu_addr = 22'h020; cpu_rd = 1'b1; ppu_rd = 1'b1;
    exp_ppu(r + 3, 8'h22);
    exp_cpu(r + 5, 8'h11, 1'b1);
    tick();
    probe("t2_ppu_issue_addr", S_ADDR, 32'h020);
    tick_n(2);
    probe("t2_cpu_issue_addr", S_ADDR, 32'h010);
    tick_n(6);

    // CPU write, then a read requested in the write's issue cycle.
    r = cyc; cpu_addr = 22'h3FF; cpu_din = 8'h5C; cpu_wr = 1'b1;
    exp_wr(r + 1, 22'h3FF, 8'h5C);
    exp_cpu(r + 1, 8'h00, 1'b0);
    tick();
    cpu_rd = 1'b1;
    exp_cpu(r + 4, 8'h5C, 1'b1);
    tick();
    tick_n(6);
    probe("t3_no_overrun", S_OVR, 32'h0);

    // cpu_rd with cpu_wr together counts as a write.
    r = cyc; cpu_addr = 22'h200; cpu_din = 8'h77; cpu_rd = 1'b1; cpu_wr = 1'b1;
    exp_wr(r + 1, 22'h200, 8'h77);
    exp_cpu(r + 1, 8'h00, 1'b0);
    tick();
    tick_n(4);
    r = cyc; cpu_rd = 1'b1;
    exp_cpu(r + 3, 8'h77, 1'b1);
    tick();
    tick_n(6);

    // Loader owns the RAM: CPU/PPU pulses are dropped.
    r = cyc; ld_active = 1'b1; ld_addr = 22'h000; ld_din = 8'hEA; ld_wr = 1'b1;
    cpu_addr = 22'h100; cpu_rd = 1'b1;
    exp_wr(r + 1, 22'h000, 8'hEA);
    tick();
    ppu_addr = 22'h020; ppu_rd = 1'b1;
    tick();
    tick();
    ld_active = 1'b0;
    tick_n(6);
    r = cyc; cpu_addr = 22'h000; cpu_rd = 1'b1;
    exp_cpu(r + 3, 8'hEA, 1'b1);
    tick();
    tick_n(6);

    // Two PPU pulses while the CPU read is waiting: second replaces first.
    r = cyc; cpu_addr = 22'h030; cpu_rd = 1'b1;
    exp_cpu(r + 3, 8'h33, 1'b1);
    tick();
    ppu_addr = 22'h040; ppu_rd = 1'b1;
    tick();
    probe("t5_overrun_before", S_OVR, 32'h0);
    ppu_addr = 22'h041; ppu_rd = 1'b1;
    exp_ppu(r + 5, 8'h45);
    tick();
    probe("t5_overrun_set", S_OVR, 32'h1);
    probe("t5_ppu_issue_addr", S_ADDR, 32'h041);
    tick_n(6);
    probe("t5_overrun_sticky", S_OVR, 32'h1);

    // Reset in READ_WAIT abandons the read.
    cpu_addr = 22'h010; cpu_rd = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    probe("t6_cpu_q",    S_CPUQ, 32'h0);
    probe("t6_ppu_q",    S_PPUQ, 32'h0);
    probe("t6_overrun",  S_OVR,  32'h0);
    probe("t6_ram_addr", S_ADDR, 32'h0);
    probe("t6_ram_we",   S_WE,   32'h0);
    probe("t6_cpu_valid",S_CPUV, 32'h0);
    reset = 1'b0;
    tick_n(4);
    r = cyc; cpu_addr = 22'h100; cpu_rd = 1'b1;
    exp_cpu(r + 3, 8'hA5, 1'b1);
    tick();
    tick_n(6);

    stim_done = 1'b1;
  end

endmodule
